// File: rtl/spr_pkg.sv
// Shared widths, latency and helpers for the interpolation divider pipeline.
package spr_pkg;

    localparam int unsigned DB_W    = 17;
    localparam int unsigned BOUND_W = 12;
    localparam int unsigned INT_W   = 4;
    localparam int unsigned DIV_W   = 7;
    localparam int unsigned SUM_W   = 18;
    localparam int unsigned LAT     = 19;

    localparam logic [BOUND_W-1:0] SAT_MAX = BOUND_W'(4095);

    typedef struct packed {
        logic [BOUND_W-1:0] lobound;
        logic               valid;
        logic               hs;
        logic               vs;
    } side_t;

    // Interval 0 stands for 16, so the divisor is never zero.
    function automatic logic [DIV_W-1:0] make_divisor(input logic [INT_W-1:0] interval);
        return (interval == '0) ? DIV_W'(64) : DIV_W'({interval, 2'b00});
    endfunction

endpackage

// File: rtl/div_stage.sv
// One registered restoring-division step resolving quotient bit BIT.
module div_stage
    import spr_pkg::*;
#(
    parameter int unsigned BIT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] rem_in,
    input  logic [DB_W-1:0]  dividend_in,
    input  logic [DIV_W-1:0] divisor_in,
    input  logic [DB_W-1:0]  quot_in,
    input  side_t            side_in,
    output logic [DIV_W-1:0] rem_out,
    output logic [DB_W-1:0]  dividend_out,
    output logic [DIV_W-1:0] divisor_out,
    output logic [DB_W-1:0]  quot_out,
    output side_t            side_out
);

    logic [DIV_W:0]   trial;
    logic [DIV_W:0]   diff;
    logic             fits;
    logic [DIV_W-1:0] rem_next;
    logic [DB_W-1:0]  quot_next;

    // Remainder stays below the divisor (<= 64), so trial fits in DIV_W+1 bits.
    always_comb begin
        trial     = {rem_in, dividend_in[BIT]};
        diff      = trial - {1'b0, divisor_in};
        fits      = (trial >= {1'b0, divisor_in});
        rem_next  = fits ? diff[DIV_W-1:0] : trial[DIV_W-1:0];
        quot_next = quot_in;
        quot_next[BIT] = fits;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_out      <= '0;
            dividend_out <= '0;
            divisor_out  <= '0;
            quot_out     <= '0;
            side_out     <= '0;
        end else begin
            rem_out      <= rem_next;
            dividend_out <= dividend_in;
            divisor_out  <= divisor_in;
            quot_out     <= quot_next;
            side_out     <= side_in;
        end
    end

endmodule

// File: rtl/interp_divider.sv
// Pipelined lobound + delta/(4*interval) interpolator with saturation and sync passthrough.
module interp_divider
    import spr_pkg::*;
#(
    parameter int unsigned LAT = spr_pkg::LAT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_hs,
    input  logic               i_vs,
    input  logic [INT_W-1:0]   interval_in,
    input  logic [DB_W-1:0]    delta_bound_in,
    input  logic [BOUND_W-1:0] lobound_in,
    output logic [BOUND_W-1:0] pixel_out,
    output logic               o_hs,
    output logic               o_vs
);

    localparam int unsigned STAGES = LAT - 2;

    logic [INT_W-1:0]   interval_d1;
    logic [BOUND_W-1:0] lobound_d1;
    logic [BOUND_W-1:0] lobound_d2;

    logic [DIV_W-1:0] rem_ch  [STAGES+1];
    logic [DB_W-1:0]  db_ch   [STAGES+1];
    logic [DIV_W-1:0] div_ch  [STAGES+1];
    logic [DB_W-1:0]  quot_ch [STAGES+1];
    side_t            side_ch [STAGES+1];

    logic [SUM_W-1:0] sum;
    logic             unused_tail;

    // Skew registers line interval and lobound up with their delta sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            interval_d1 <= '0;
            lobound_d1  <= '0;
            lobound_d2  <= '0;
            db_ch[0]    <= '0;
            div_ch[0]   <= '0;
            side_ch[0]  <= '0;
        end else begin
            interval_d1 <= interval_in;
            lobound_d1  <= lobound_in;
            lobound_d2  <= lobound_d1;
            db_ch[0]    <= delta_bound_in;
            div_ch[0]   <= make_divisor(interval_d1);
            side_ch[0]  <= '{lobound: lobound_d2, valid: i_hs & i_vs, hs: i_hs, vs: i_vs};
        end
    end

    assign rem_ch[0]  = '0;
    assign quot_ch[0] = '0;

    for (genvar i = 0; i < STAGES; i++) begin : g_div
        div_stage #(
            .BIT(DB_W - 1 - i)
        ) u_stage (
            .clk          (clk),
            .rst_n        (rst_n),
            .rem_in       (rem_ch[i]),
            .dividend_in  (db_ch[i]),
            .divisor_in   (div_ch[i]),
            .quot_in      (quot_ch[i]),
            .side_in      (side_ch[i]),
            .rem_out      (rem_ch[i+1]),
            .dividend_out (db_ch[i+1]),
            .divisor_out  (div_ch[i+1]),
            .quot_out     (quot_ch[i+1]),
            .side_out     (side_ch[i+1])
        );
    end

    assign sum         = SUM_W'(side_ch[STAGES].lobound) + SUM_W'(quot_ch[STAGES]);
    assign unused_tail = ^{rem_ch[STAGES], db_ch[STAGES], div_ch[STAGES]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_out <= '0;
            o_hs      <= 1'b0;
            o_vs      <= 1'b0;
        end else begin
            if (!side_ch[STAGES].valid)
                pixel_out <= '0;
            else if (sum > SUM_W'(SAT_MAX))
                pixel_out <= SAT_MAX;
            else
                pixel_out <= sum[BOUND_W-1:0];
            o_hs <= side_ch[STAGES].hs;
            o_vs <= side_ch[STAGES].vs;
        end
    end

endmodule

// File: tb/tb_interp_divider.sv
// Scoreboard bench for interp_divider: directed corner pixels, blanking, mid-stream reset, random stream.
module tb_interp_divider;

    localparam int N     = 10010;
    localparam int R     = 5000;
    localparam int LAT_C = 19;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_hs, i_vs;
    logic [3:0]  interval_in;
    logic [16:0] delta_bound_in;
    logic [11:0] lobound_in;
    logic [11:0] pixel_out;
    logic        o_hs, o_vs;

    interp_divider #(.LAT(LAT_C)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_hs           (i_hs),
        .i_vs           (i_vs),
        .interval_in    (interval_in),
        .delta_bound_in (delta_bound_in),
        .lobound_in     (lobound_in),
        .pixel_out      (pixel_out),
        .o_hs           (o_hs),
        .o_vs           (o_vs)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned due;
        int unsigned idx;
        logic [11:0] pix;
        logic        hs;
        logic        vs;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;
    bit          idle_chk;

    logic [3:0]  iv   [N];
    logic [16:0] db   [N];
    logic [11:0] lb   [N];
    logic        hs_a [N];
    logic        vs_a [N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] ref_pix(input int p);
        int unsigned d, s;
        if (!(hs_a[p] && vs_a[p])) return 12'd0;
        d = (iv[p] == 4'd0) ? 64 : 4 * int'(iv[p]);
        s = int'(lb[p]) + int'(db[p]) / d;
        return (s > 4095) ? 12'd4095 : 12'(s);
    endfunction

    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (sb.size() != 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check($sformatf("pix[%0d]", e.idx), 32'(pixel_out), 32'(e.pix));
            check($sformatf("hs[%0d]", e.idx),  32'(o_hs),      32'(e.hs));
            check($sformatf("vs[%0d]", e.idx),  32'(o_vs),      32'(e.vs));
            idle_chk = 1'b0;
        end else if (idle_chk) begin
            check("idle_pix", 32'(pixel_out), 32'd0);
            check("idle_hs",  32'(o_hs),      32'd0);
        end
    endtask

    task automatic drive_zero();
        i_hs = 1'b0; i_vs = 1'b0; interval_in = '0; delta_bound_in = '0; lobound_in = '0;
    endtask

    // Two blanking cycles that pre-load interval/lobound for pixel p.
    task automatic preamble(input int p);
        tick();
        drive_zero();
        lobound_in = lb[p];
        tick();
        drive_zero();
        interval_in = iv[p];
        lobound_in  = (p + 1 < N) ? lb[p+1] : '0;
    endtask

    task automatic drive_pix(input int p);
        exp_t e;
        tick();
        delta_bound_in = db[p];
        i_hs           = hs_a[p];
        i_vs           = vs_a[p];
        interval_in    = (p + 1 < N) ? iv[p+1] : '0;
        lobound_in     = (p + 2 < N) ? lb[p+2] : '0;
        e.due = cyc + LAT_C;
        e.idx = p;
        e.pix = ref_pix(p);
        e.hs  = hs_a[p];
        e.vs  = vs_a[p];
        sb.push_back(e);
    endtask

    initial begin
        for (int p = 0; p < N; p++) begin
            iv[p]   = 4'($urandom_range(0, 15));
            db[p]   = 17'($urandom_range(0, 131071));
            lb[p]   = 12'($urandom_range(0, 4095));
            hs_a[p] = ($urandom_range(0, 7) != 0);
            vs_a[p] = ($urandom_range(0, 7) != 0);
        end
        iv[0] = 4'd4;  db[0] = 17'd4096;   lb[0] = 12'h100; hs_a[0] = 1'b1; vs_a[0] = 1'b1;
        iv[1] = 4'd0;  db[1] = 17'd6400;   lb[1] = 12'h010; hs_a[1] = 1'b1; vs_a[1] = 1'b1;
        iv[2] = 4'd1;  db[2] = 17'd68850;  lb[2] = 12'hF00; hs_a[2] = 1'b1; vs_a[2] = 1'b1;
        iv[3] = 4'd7;  db[3] = 17'd1000;   lb[3] = 12'h123; hs_a[3] = 1'b1; vs_a[3] = 1'b1;
        for (int p = 4; p < 7; p++) begin
            hs_a[p] = 1'b0; vs_a[p] = 1'b1;
        end
        iv[7] = 4'd15; db[7] = 17'd131071; lb[7] = 12'h000; hs_a[7] = 1'b1; vs_a[7] = 1'b1;
        hs_a[R] = 1'b1; vs_a[R] = 1'b1;

        rst_n = 1'b1;
        drive_zero();
        #2 rst_n = 1'b0;
        #1;
        check("reset_pix", 32'(pixel_out), 32'd0);
        check("reset_hs",  32'(o_hs),      32'd0);
        check("reset_vs",  32'(o_vs),      32'd0);
        idle_chk = 1'b1;
        tick();
        rst_n = 1'b1;
        preamble(0);

        for (int p = 0; p < N; p++) begin
            if (p == R) begin
                tick();
                rst_n = 1'b0;
                drive_zero();
                #1;
                check("midrst_pix", 32'(pixel_out), 32'd0);
                check("midrst_hs",  32'(o_hs),      32'd0);
                check("midrst_vs",  32'(o_vs),      32'd0);
                sb.delete();
                idle_chk = 1'b1;
                tick();
                rst_n = 1'b1;
                preamble(R);
            end
            drive_pix(p);
        end

        repeat (LAT_C + 5) begin
            tick();
            drive_zero();
        end
        check("drain_left", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
